// File: rtl/a5_pkg.sv
// rtl/a5_pkg.sv - shared state encoding, A5/1 tap positions and default phase lengths
package a5_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        KEY,
        FRAME,
        MIX,
        STREAM
    } a5_state_e;

    // Clocking-tap and output positions inside the external R1/R2/R3 registers
    localparam int R1_LEN     = 19;
    localparam int R2_LEN     = 22;
    localparam int R3_LEN     = 23;
    localparam int R1_CLK_TAP = 8;
    localparam int R2_CLK_TAP = 10;
    localparam int R3_CLK_TAP = 10;

    localparam int DEF_KEY_BITS   = 64;
    localparam int DEF_FRAME_BITS = 22;
    localparam int DEF_MIX_CYCLES = 100;
    localparam int DEF_KS_BITS    = 228;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/a5_majority_clk.sv
// rtl/a5_majority_clk.sv - A5/1 majority rule: enable every register whose tap agrees with the majority
module a5_majority_clk
    import a5_pkg::*;
(
    input  logic [2:0] clk_bit_i,
    output logic [2:0] clk_en_o
);

    logic maj;

    assign maj = (clk_bit_i[0] & clk_bit_i[1]) |
                 (clk_bit_i[0] & clk_bit_i[2]) |
                 (clk_bit_i[1] & clk_bit_i[2]);

    // At most one tap can disagree, so at least two registers always step
    assign clk_en_o = ~(clk_bit_i ^ {3{maj}});

endmodule

// File: rtl/a5_keystream_ctrl.sv
// rtl/a5_keystream_ctrl.sv - A5/1 session sequencer driving three external LFSRs and a keystream handshake
module a5_keystream_ctrl
    import a5_pkg::*;
#(
    parameter int KEY_BITS   = DEF_KEY_BITS,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int MIX_CYCLES = DEF_MIX_CYCLES,
    parameter int KS_BITS    = DEF_KS_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic [2:0]            lfsr_clk_bit,
    input  logic [2:0]            lfsr_q,
    output logic                  lfsr_load,
    output logic [2:0]            lfsr_clk_en,
    output logic                  lfsr_d,
    output logic                  ks_valid,
    output logic                  ks_bit,
    input  logic                  ks_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W   = $clog2(max4(KEY_BITS, FRAME_BITS, MIX_CYCLES, KS_BITS) + 1);
    localparam int KEY_IW  = $clog2(KEY_BITS);
    localparam int FRM_IW  = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0] KS_LOAD    = CNT_W'(KS_BITS);

    a5_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ks_valid_q, ks_valid_d;
    logic             done_q, done_d;
    logic [2:0]       maj_en;
    logic [KEY_IW-1:0] key_idx;
    logic [FRM_IW-1:0] frame_idx;
    logic             stream_step;
    logic             stream_accept;

    a5_majority_clk u_majority (
        .clk_bit_i (lfsr_clk_bit),
        .clk_en_o  (maj_en)
    );

    // The counter runs down, so the serial index is its distance from the top
    assign key_idx   = KEY_IW'(KEY_LAST - cnt_q);
    assign frame_idx = FRM_IW'(FRAME_LAST - cnt_q);

    // In STREAM the counter holds the number of LFSR clocks still owed to the sink
    assign stream_step   = (!ks_valid_q || ks_ready) && (cnt_q != '0);
    assign stream_accept = ks_valid_q && ks_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ks_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ks_valid_q <= ks_valid_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ks_valid_d  = ks_valid_q;
        done_d      = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_clk_en = 3'b000;
        lfsr_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                lfsr_load = 1'b1;
                state_d   = KEY;
                cnt_d     = KEY_LAST;
            end
            KEY: begin
                lfsr_clk_en = 3'b111;
                lfsr_d      = key[key_idx];
                cnt_d       = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = FRAME;
                    cnt_d   = FRAME_LAST;
                end
            end
            FRAME: begin
                lfsr_clk_en = 3'b111;
                lfsr_d      = frame[frame_idx];
                cnt_d       = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = MIX;
                    cnt_d   = MIX_LAST;
                end
            end
            MIX: begin
                lfsr_clk_en = maj_en;
                cnt_d       = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = STREAM;
                    cnt_d   = KS_LOAD;
                end
            end
            STREAM: begin
                // Stepping only when the output slot is free keeps ks_bit frozen during stalls
                if (stream_step) begin
                    lfsr_clk_en = maj_en;
                    cnt_d       = cnt_q - 1'b1;
                    ks_valid_d  = 1'b1;
                end else if (stream_accept) begin
                    ks_valid_d = 1'b0;
                    state_d    = IDLE;
                    done_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort and reset leave the LFSR contents exactly as they were
        if (abort || reset) begin
            state_d     = IDLE;
            cnt_d       = '0;
            ks_valid_d  = 1'b0;
            done_d      = 1'b0;
            lfsr_load   = 1'b0;
            lfsr_clk_en = 3'b000;
            lfsr_d      = 1'b0;
        end
    end

    assign ks_valid = ks_valid_q;
    assign ks_bit   = ks_valid_q & (^lfsr_q);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule
